// File: rtl/pg_pkg.sv
// Shared generate/propagate pair type and the single-bit pg functions
// used by the prefix-adder input stage.
package pg_pkg;

    typedef struct packed {
        logic gen;
        logic prop;
    } pg_t;

    function automatic pg_t pg_bit(input logic x, input logic y);
        pg_t r;
        r.gen  = x & y;
        r.prop = x ^ y;
        return r;
    endfunction

    // Carry-in folded into the generate term: gen becomes majority(x, y, c_in).
    function automatic pg_t pg_bit_cin(input logic x, input logic y, input logic c_in);
        pg_t r;
        r.gen  = (x & y) | (c_in & (x | y));
        r.prop = x ^ y;
        return r;
    endfunction

endpackage

// File: rtl/pg_in_if.sv
// Operand/result bundle for the pg input stage; master drives operands,
// slave (the pg_in block) returns generate/propagate.
interface pg_in_if #(parameter int WIDTH = 1);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c_in;
    logic             in_valid;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             out_valid;

    modport master (
        output x, y, c_in, in_valid,
        input  gen, prop, out_valid
    );

    modport slave (
        input  x, y, c_in, in_valid,
        output gen, prop, out_valid
    );

endinterface

// File: rtl/pg_cell.sv
// Single-bit generate/propagate cell for operand bits above the carry-in bit.
module pg_cell
    import pg_pkg::*;
(
    input  logic x,
    input  logic y,
    output logic gen,
    output logic prop
);

    pg_t pg;

    assign pg   = pg_bit(x, y);
    assign gen  = pg.gen;
    assign prop = pg.prop;

endmodule

// File: rtl/pg_in.sv
// Prefix-adder input stage: per-bit generate/propagate with carry-in folded
// into bit 0, optionally registered on clk.
module pg_in
    import pg_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic    clk,
    input  logic    rst,
    pg_in_if.slave  bus
);

    logic [WIDTH-1:0] gen_c;
    logic [WIDTH-1:0] prop_c;
    pg_t              pg0;

    assign pg0       = pg_bit_cin(bus.x[0], bus.y[0], bus.c_in);
    assign gen_c[0]  = pg0.gen;
    assign prop_c[0] = pg0.prop;

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_cell
        pg_cell u_cell (
            .x    (bus.x[gi]),
            .y    (bus.y[gi]),
            .gen  (gen_c[gi]),
            .prop (prop_c[gi])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] gen_q;
        logic [WIDTH-1:0] prop_q;
        logic             valid_q;

        // Data registers only load on valid beats; valid itself tracks every edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gen_q   <= '0;
                prop_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    gen_q  <= gen_c;
                    prop_q <= prop_c;
                end
            end
        end

        assign bus.gen       = gen_q;
        assign bus.prop      = prop_q;
        assign bus.out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = ^{clk, rst};
        assign bus.gen        = gen_c;
        assign bus.prop       = prop_c;
        assign bus.out_valid  = bus.in_valid;
    end

endmodule

// File: tb/tb_pg_in.sv
// Self-checking bench for pg_in: truth-table sweep, directed vectors,
// registered-mode sequences and randomized runs against a reference model.
module tb_pg_in;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pg_in_if #(.WIDTH(1)) if_w1  ();
    pg_in_if #(.WIDTH(4)) if_w4  ();
    pg_in_if #(.WIDTH(8)) if_w8  ();
    pg_in_if #(.WIDTH(1)) if_w1r ();
    pg_in_if #(.WIDTH(8)) if_w8r ();

    pg_in #(.WIDTH(1), .REG_OUT(1'b0)) u_w1  (.clk(clk), .rst(rst), .bus(if_w1.slave));
    pg_in #(.WIDTH(4), .REG_OUT(1'b0)) u_w4  (.clk(clk), .rst(rst), .bus(if_w4.slave));
    pg_in #(.WIDTH(8), .REG_OUT(1'b0)) u_w8  (.clk(clk), .rst(rst), .bus(if_w8.slave));
    pg_in #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (.clk(clk), .rst(rst), .bus(if_w1r.slave));
    pg_in #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (.clk(clk), .rst(rst), .bus(if_w8r.slave));

    typedef struct {
        logic [2:0] xyc;
        logic [1:0] gp;
    } vec1_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       c;
        logic [3:0] gen;
        logic [3:0] prop;
    } vec4_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: generate is x AND y except bit 0, which is set when at least
    // two of x[0], y[0], c_in are 1; propagate is x XOR y.
    function automatic logic [7:0] ref_gen(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [7:0] g;
        int         ones;
        g    = x & y;
        ones = int'(x[0]) + int'(y[0]) + int'(c);
        g[0] = (ones >= 2);
        return g;
    endfunction

    function automatic logic [7:0] ref_prop(input logic [7:0] x, input logic [7:0] y);
        return x ^ y;
    endfunction

    vec1_t      tab1 [8];
    vec4_t      tab4 [3];
    logic [7:0] eg, ep;
    logic       ev;
    logic [31:0] r;

    initial begin
        tab1[0] = '{3'b000, 2'b00};
        tab1[1] = '{3'b001, 2'b00};
        tab1[2] = '{3'b010, 2'b01};
        tab1[3] = '{3'b011, 2'b11};
        tab1[4] = '{3'b100, 2'b01};
        tab1[5] = '{3'b101, 2'b11};
        tab1[6] = '{3'b110, 2'b10};
        tab1[7] = '{3'b111, 2'b10};

        tab4[0] = '{4'b1010, 4'b0110, 1'b1, 4'b0010, 4'b1100};
        tab4[1] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001};
        tab4[2] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001};

        {if_w1.x, if_w1.y, if_w1.c_in, if_w1.in_valid}     = '0;
        {if_w4.x, if_w4.y, if_w4.c_in, if_w4.in_valid}     = '0;
        {if_w8.x, if_w8.y, if_w8.c_in, if_w8.in_valid}     = '0;
        {if_w1r.x, if_w1r.y, if_w1r.c_in, if_w1r.in_valid} = '0;
        {if_w8r.x, if_w8r.y, if_w8r.c_in, if_w8r.in_valid} = '0;

        // Registered outputs held at zero during reset, even with valid inputs.
        if_w1r.x = 1'b1; if_w1r.y = 1'b1; if_w1r.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gen",  8'(if_w1r.gen),       8'h00);
        check("rst_prop", 8'(if_w1r.prop),      8'h00);
        check("rst_vld",  8'(if_w1r.out_valid), 8'h00);
        check("rst_w8r",  if_w8r.gen | if_w8r.prop, 8'h00);

        // Combinational instances run while rst is still high.
        if_w1.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {if_w1.x, if_w1.y, if_w1.c_in} = tab1[i].xyc;
            #1;
            check($sformatf("w1_tab%0d", i), 8'({if_w1.gen, if_w1.prop}), 8'(tab1[i].gp));
            check("w1_vld", 8'(if_w1.out_valid), 8'h01);
        end
        if_w1.in_valid = 1'b0;
        #1;
        check("w1_vld_low", 8'(if_w1.out_valid), 8'h00);

        if_w4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_w4.x = tab4[i].x; if_w4.y = tab4[i].y; if_w4.c_in = tab4[i].c;
            #1;
            check($sformatf("w4_gen%0d", i),  8'(if_w4.gen),  8'(tab4[i].gen));
            check($sformatf("w4_prop%0d", i), 8'(if_w4.prop), 8'(tab4[i].prop));
        end

        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            if_w8.x = r[7:0]; if_w8.y = r[15:8]; if_w8.c_in = r[16]; if_w8.in_valid = r[17];
            #1;
            check("w8_gen",  if_w8.gen,  ref_gen(r[7:0], r[15:8], r[16]));
            check("w8_prop", if_w8.prop, ref_prop(r[7:0], r[15:8]));
            check("w8_vld",  8'(if_w8.out_valid), 8'(r[17]));
        end

        // Registered WIDTH=1: one edge of latency after reset release.
        @(negedge clk);
        rst = 1'b0;
        if_w1r.x = 1'b1; if_w1r.y = 1'b1; if_w1r.c_in = 1'b0; if_w1r.in_valid = 1'b1;
        #1;
        check("lat_early_gen", 8'(if_w1r.gen),       8'h00);
        check("lat_early_vld", 8'(if_w1r.out_valid), 8'h00);
        @(posedge clk);
        #1;
        check("lat_gen",  8'(if_w1r.gen),       8'h01);
        check("lat_prop", 8'(if_w1r.prop),      8'h00);
        check("lat_vld",  8'(if_w1r.out_valid), 8'h01);

        // Mid-stream reset discards the pending capture; comb path ignores it.
        @(negedge clk);
        if_w1r.x = 1'b1; if_w1r.y = 1'b0; if_w1r.c_in = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_gen",  8'(if_w1r.gen),       8'h00);
        check("mid_rst_prop", 8'(if_w1r.prop),      8'h00);
        check("mid_rst_vld",  8'(if_w1r.out_valid), 8'h00);
        check("comb_rst_gen", 8'(if_w4.gen),        8'h00);
        check("comb_rst_prop",8'(if_w4.prop),       8'h01);
        check("comb_rst_vld", 8'(if_w4.out_valid),  8'h01);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_hold", 8'({if_w1r.gen, if_w1r.prop, if_w1r.out_valid}), 8'h00);
        @(posedge clk);
        #1;
        check("post_rst_gen",  8'(if_w1r.gen),       8'h01);
        check("post_rst_prop", 8'(if_w1r.prop),      8'h01);
        check("post_rst_vld",  8'(if_w1r.out_valid), 8'h01);

        // Invalid beat: data holds, valid drops.
        @(negedge clk);
        if_w1r.x = 1'b0; if_w1r.y = 1'b0; if_w1r.c_in = 1'b0; if_w1r.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("hold_gen",  8'(if_w1r.gen),       8'h01);
        check("hold_prop", 8'(if_w1r.prop),      8'h01);
        check("hold_vld",  8'(if_w1r.out_valid), 8'h00);

        // Randomized registered WIDTH=8 run with a held-value reference.
        eg = '0; ep = '0; ev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check("w8r_gen",  if_w8r.gen,  eg);
            check("w8r_prop", if_w8r.prop, ep);
            check("w8r_vld",  8'(if_w8r.out_valid), 8'(ev));
            r = $urandom;
            if_w8r.x = r[7:0]; if_w8r.y = r[15:8]; if_w8r.c_in = r[16];
            if_w8r.in_valid = (r[19:18] != 2'b00);
            ev = if_w8r.in_valid;
            if (ev) begin
                eg = ref_gen(r[7:0], r[15:8], r[16]);
                ep = ref_prop(r[7:0], r[15:8]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
